// File: rtl/safe_lock_controller.sv
// Safe lock sequencer: keypad entry, code check, attempt limit,
// unlock/relock timing, lockout alarm and passcode reprogramming.
module safe_lock_controller #(
    parameter int DIGITS         = 4,
    parameter int MAX_TRIES      = 3,
    parameter int FAIL_CYCLES    = 50,
    parameter int OPEN_CYCLES    = 1000,
    parameter int LOCKOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       enter,
    input  logic       clear,
    input  logic       program_req,
    input  logic       match,
    output logic       shift_en,
    output logic [3:0] shift_digit,
    output logic       entry_clear,
    output logic       store_load,
    output logic       unlocked,
    output logic       fail_flash,
    output logic       alarm,
    output logic [2:0] digit_count,
    output logic [1:0] tries_left
);

    localparam int M1   = (FAIL_CYCLES > OPEN_CYCLES) ? FAIL_CYCLES : OPEN_CYCLES;
    localparam int MAXC = (M1 > LOCKOUT_CYCLES) ? M1 : LOCKOUT_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

    localparam logic [TW-1:0] T_FAIL = TW'(FAIL_CYCLES - 1);
    localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [2:0]    DIG    = 3'(DIGITS);
    localparam logic [1:0]    TRIES  = 2'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        FAIL,
        LOCKOUT,
        OPEN,
        PROG
    } state_e;

    state_e        state_q;
    logic [TW-1:0] tmr_q;
    logic [2:0]    cnt_q;
    logic [1:0]    tries_q;
    logic          force_fail_q;
    logic          clr_pend_q;
    logic          shift_en_q;
    logic [3:0]    shift_digit_q;
    logic          entry_clear_q;
    logic          store_load_q;
    logic          unlocked_q;
    logic          fail_flash_q;
    logic          alarm_q;

    logic full;
    logic tmr_zero;

    assign full     = (cnt_q == DIG);
    assign tmr_zero = (tmr_q == '0);

    // Sequencer FSM; every output is a register, indicators lag state by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tmr_q         <= '0;
            cnt_q         <= '0;
            tries_q       <= TRIES;
            force_fail_q  <= 1'b0;
            clr_pend_q    <= 1'b0;
            shift_en_q    <= 1'b0;
            shift_digit_q <= '0;
            entry_clear_q <= 1'b0;
            store_load_q  <= 1'b0;
            unlocked_q    <= 1'b0;
            fail_flash_q  <= 1'b0;
            alarm_q       <= 1'b0;
        end else begin
            shift_en_q    <= 1'b0;
            entry_clear_q <= clr_pend_q;
            store_load_q  <= 1'b0;
            clr_pend_q    <= 1'b0;
            unlocked_q    <= (state_q == OPEN) || (state_q == PROG);
            fail_flash_q  <= (state_q == FAIL);
            alarm_q       <= (state_q == LOCKOUT);
            unique case (state_q)
                IDLE: begin
                    // a key arriving while the post-store clear is pending is dropped
                    if (!clear && !enter && key_valid && !clr_pend_q) begin
                        shift_en_q    <= 1'b1;
                        shift_digit_q <= key_digit;
                        cnt_q         <= 3'd1;
                        state_q       <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (clear) begin
                        entry_clear_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= IDLE;
                    end else if (enter) begin
                        force_fail_q <= !full;
                        state_q      <= CHECK;
                    end else if (key_valid && !full) begin
                        shift_en_q    <= 1'b1;
                        shift_digit_q <= key_digit;
                        cnt_q         <= cnt_q + 3'd1;
                    end
                end
                CHECK: begin
                    if (match && !force_fail_q) begin
                        tries_q <= TRIES;
                        tmr_q   <= T_OPEN;
                        state_q <= OPEN;
                    end else if (tries_q <= 2'd1) begin
                        tries_q <= '0;
                        tmr_q   <= T_LOCK;
                        state_q <= LOCKOUT;
                    end else begin
                        tries_q <= tries_q - 2'd1;
                        tmr_q   <= T_FAIL;
                        state_q <= FAIL;
                    end
                end
                FAIL: begin
                    if (tmr_zero) begin
                        entry_clear_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= IDLE;
                    end else begin
                        tmr_q <= tmr_q - T_ONE;
                    end
                end
                LOCKOUT: begin
                    if (tmr_zero) begin
                        tries_q       <= TRIES;
                        entry_clear_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= IDLE;
                    end else begin
                        tmr_q <= tmr_q - T_ONE;
                    end
                end
                OPEN: begin
                    if (tmr_zero || (enter && !clear)) begin
                        entry_clear_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= IDLE;
                    end else if (program_req) begin
                        entry_clear_q <= 1'b1;
                        cnt_q         <= '0;
                        tmr_q         <= T_OPEN;
                        state_q       <= PROG;
                    end else begin
                        tmr_q <= tmr_q - T_ONE;
                    end
                end
                PROG: begin
                    if (tmr_zero) begin
                        entry_clear_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= IDLE;
                    end else if (clear || (enter && !full)) begin
                        entry_clear_q <= 1'b1;
                        cnt_q         <= '0;
                        tmr_q         <= T_OPEN;
                        state_q       <= OPEN;
                    end else if (enter) begin
                        // store now, clear the input register one cycle later
                        store_load_q <= 1'b1;
                        clr_pend_q   <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= IDLE;
                    end else begin
                        tmr_q <= tmr_q - T_ONE;
                        if (key_valid && !full) begin
                            shift_en_q    <= 1'b1;
                            shift_digit_q <= key_digit;
                            cnt_q         <= cnt_q + 3'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign shift_en    = shift_en_q;
    assign shift_digit = shift_digit_q;
    assign entry_clear = entry_clear_q;
    assign store_load  = store_load_q;
    assign unlocked    = unlocked_q;
    assign fail_flash  = fail_flash_q;
    assign alarm       = alarm_q;
    assign digit_count = cnt_q;
    assign tries_left  = tries_q;

endmodule
